// File: rtl/roi_moments.sv
// Streaming region-of-interest moments: per-frame active-pixel count, coordinate sums and bounding box.
// Define ROI_MOMENTS_SECOND_ORDER_EN to add the m20/m02/m11 second-order moment outputs.
module roi_moments #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 12,
    parameter int ACC_W   = 32,
    parameter int ACC2_W  = 48
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic [DATA_W-1:0]  s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tuser,
    input  logic               s_tlast,
    input  logic [DATA_W-1:0]  thr,
    output logic [ACC_W-1:0]   m00,
    output logic [ACC_W-1:0]   m10,
    output logic [ACC_W-1:0]   m01,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
`ifdef ROI_MOMENTS_SECOND_ORDER_EN
    output logic [ACC2_W-1:0]  m20,
    output logic [ACC2_W-1:0]  m02,
    output logic [ACC2_W-1:0]  m11,
`endif
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_overrun
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state;
    logic [COORD_W-1:0]   x_cnt, y_cnt;
    logic                 line_end;
    logic [COORD_W-1:0]   cur_x, cur_y;
    logic                 pix_on, take_beat, frame_done;

    logic [ACC_W-1:0]     acc00, acc10, acc01;
    logic [COORD_W-1:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [ACC_W-1:0]     base00, base10, base01;
    logic [COORD_W-1:0]   base_xmin, base_xmax, base_ymin, base_ymax;
    logic [ACC_W-1:0]     nxt00, nxt10, nxt01;
    logic [COORD_W-1:0]   nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;

    assign s_tready   = 1'b1;
    assign pix_on     = s_tdata > thr;
    assign take_beat  = s_tvalid & ((state == ACTIVE) | s_tuser);
    assign frame_done = s_tvalid & s_tuser & (state == ACTIVE);

    // Coordinate of the beat being accepted, derived from the previous beat's position.
    always_comb begin
        cur_x = x_cnt + COORD_W'(1);
        cur_y = y_cnt;
        if (s_tuser) begin
            cur_x = '0;
            cur_y = '0;
        end else if (line_end) begin
            cur_x = '0;
            cur_y = y_cnt + COORD_W'(1);
        end
    end

    // A start-of-frame beat restarts the accumulation from this pixel alone.
    always_comb begin
        base00    = s_tuser ? '0 : acc00;
        base10    = s_tuser ? '0 : acc10;
        base01    = s_tuser ? '0 : acc01;
        base_xmin = s_tuser ? '1 : acc_xmin;
        base_xmax = s_tuser ? '0 : acc_xmax;
        base_ymin = s_tuser ? '1 : acc_ymin;
        base_ymax = s_tuser ? '0 : acc_ymax;

        nxt00    = base00 + ACC_W'(pix_on);
        nxt10    = base10 + (pix_on ? ACC_W'(cur_x) : '0);
        nxt01    = base01 + (pix_on ? ACC_W'(cur_y) : '0);
        nxt_xmin = (pix_on && cur_x < base_xmin) ? cur_x : base_xmin;
        nxt_xmax = (pix_on && cur_x > base_xmax) ? cur_x : base_xmax;
        nxt_ymin = (pix_on && cur_y < base_ymin) ? cur_y : base_ymin;
        nxt_ymax = (pix_on && cur_y > base_ymax) ? cur_y : base_ymax;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state    <= IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            line_end <= 1'b0;
            acc00    <= '0;
            acc10    <= '0;
            acc01    <= '0;
            acc_xmin <= '0;
            acc_xmax <= '0;
            acc_ymin <= '0;
            acc_ymax <= '0;
        end else if (take_beat) begin
            state    <= ACTIVE;
            x_cnt    <= cur_x;
            y_cnt    <= cur_y;
            line_end <= s_tlast;
            acc00    <= nxt00;
            acc10    <= nxt10;
            acc01    <= nxt01;
            acc_xmin <= nxt_xmin;
            acc_xmax <= nxt_xmax;
            acc_ymin <= nxt_ymin;
            acc_ymax <= nxt_ymax;
        end
    end

    // Result registers: a completing frame always wins, even over an unread result.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m00         <= '0;
            m10         <= '0;
            m01         <= '0;
            x_min       <= '0;
            x_max       <= '0;
            y_min       <= '0;
            y_max       <= '0;
            res_valid   <= 1'b0;
            res_overrun <= 1'b0;
        end else if (frame_done) begin
            m00       <= acc00;
            m10       <= acc10;
            m01       <= acc01;
            x_min     <= acc_xmin;
            x_max     <= acc_xmax;
            y_min     <= acc_ymin;
            y_max     <= acc_ymax;
            res_valid <= 1'b1;
            if (res_valid && !res_ready)
                res_overrun <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ROI_MOMENTS_SECOND_ORDER_EN
    logic [2*COORD_W-1:0] cx_w, cy_w, p_xx, p_yy, p_xy;
    logic [ACC2_W-1:0]    acc20, acc02, acc11;

    assign cx_w = {{COORD_W{1'b0}}, cur_x};
    assign cy_w = {{COORD_W{1'b0}}, cur_y};
    assign p_xx = cx_w * cx_w;
    assign p_yy = cy_w * cy_w;
    assign p_xy = cx_w * cy_w;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            acc20 <= '0;
            acc02 <= '0;
            acc11 <= '0;
            m20   <= '0;
            m02   <= '0;
            m11   <= '0;
        end else begin
            if (take_beat) begin
                acc20 <= (s_tuser ? '0 : acc20) + (pix_on ? ACC2_W'(p_xx) : '0);
                acc02 <= (s_tuser ? '0 : acc02) + (pix_on ? ACC2_W'(p_yy) : '0);
                acc11 <= (s_tuser ? '0 : acc11) + (pix_on ? ACC2_W'(p_xy) : '0);
            end
            if (frame_done) begin
                m20 <= acc20;
                m02 <= acc02;
                m11 <= acc11;
            end
        end
    end
`endif

endmodule

// File: tb/tb_roi_moments.sv
// Directed bench for roi_moments with a result scoreboard; set ROI_MOMENTS_SECOND_ORDER_EN to match the DUT build.
module tb_roi_moments;

    localparam int DATA_W  = 8;
    localparam int COORD_W = 12;
    localparam int ACC_W   = 32;
    localparam int ACC2_W  = 48;

    typedef struct {
        logic [ACC_W-1:0]   m00, m10, m01;
        logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
        logic [ACC2_W-1:0]  m20, m02, m11;
    } res_t;

    logic               clk = 1'b0;
    logic               arstn;
    logic [DATA_W-1:0]  s_tdata;
    logic               s_tvalid, s_tready, s_tuser, s_tlast;
    logic [DATA_W-1:0]  thr;
    logic [ACC_W-1:0]   m00, m10, m01;
    logic [COORD_W-1:0] x_min, x_max, y_min, y_max;
    logic               res_valid, res_ready, res_overrun;
`ifdef ROI_MOMENTS_SECOND_ORDER_EN
    logic [ACC2_W-1:0]  m20, m02, m11;
`endif

    roi_moments #(.DATA_W(DATA_W), .COORD_W(COORD_W), .ACC_W(ACC_W), .ACC2_W(ACC2_W)) dut (
        .clk(clk), .arstn(arstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .thr(thr),
        .m00(m00), .m10(m10), .m01(m01),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
`ifdef ROI_MOMENTS_SECOND_ORDER_EN
        .m20(m20), .m02(m02), .m11(m11),
`endif
        .res_valid(res_valid), .res_ready(res_ready), .res_overrun(res_overrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    res_t sb[$];
    res_t cur, exp_out;
    logic exp_valid, exp_ovr, m_active, m_last;
    logic [COORD_W-1:0] m_x, m_y;

    logic [DATA_W-1:0]  pat_v, pat_sv;
    int                 pat_sx, pat_sy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic res_t init_res();
        res_t r;
        r.m00 = '0; r.m10 = '0; r.m01 = '0;
        r.xmin = '1; r.xmax = '0; r.ymin = '1; r.ymax = '0;
        r.m20 = '0; r.m02 = '0; r.m11 = '0;
        return r;
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r = init_res();
        r.xmin = '0;
        r.ymin = '0;
        return r;
    endfunction

    function automatic res_t add_pix(input res_t r, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input logic on);
        logic [ACC2_W-1:0] xw, yw;
        res_t o;
        o = r;
        if (on) begin
            xw = ACC2_W'(x);
            yw = ACC2_W'(y);
            o.m00 = r.m00 + 1;
            o.m10 = r.m10 + ACC_W'(x);
            o.m01 = r.m01 + ACC_W'(y);
            o.m20 = r.m20 + xw * xw;
            o.m02 = r.m02 + yw * yw;
            o.m11 = r.m11 + xw * yw;
            if (x < r.xmin) o.xmin = x;
            if (x > r.xmax) o.xmax = x;
            if (y < r.ymin) o.ymin = y;
            if (y > r.ymax) o.ymax = y;
        end
        return o;
    endfunction

    // Compares every DUT result output against one expected record.
    task automatic checkOutput(input string tag, input res_t e);
        check({tag, ".m00"}, 64'(m00), 64'(e.m00));
        check({tag, ".m10"}, 64'(m10), 64'(e.m10));
        check({tag, ".m01"}, 64'(m01), 64'(e.m01));
        check({tag, ".x_min"}, 64'(x_min), 64'(e.xmin));
        check({tag, ".x_max"}, 64'(x_max), 64'(e.xmax));
        check({tag, ".y_min"}, 64'(y_min), 64'(e.ymin));
        check({tag, ".y_max"}, 64'(y_max), 64'(e.ymax));
`ifdef ROI_MOMENTS_SECOND_ORDER_EN
        check({tag, ".m20"}, 64'(m20), 64'(e.m20));
        check({tag, ".m02"}, 64'(m02), 64'(e.m02));
        check({tag, ".m11"}, 64'(m11), 64'(e.m11));
`endif
    endtask

    // One clock cycle: drive at negedge, update the model, check the handshake flags at the next negedge.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic u, input logic l);
        logic [COORD_W-1:0] cx, cy;
        logic done, hs;
        res_t fin, item;
        s_tvalid = v; s_tdata = d; s_tuser = u; s_tlast = l;
        hs = exp_valid && res_ready;
        if (hs) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                item = sb.pop_front();
                checkOutput("handshake", item);
            end
        end
        done = 1'b0;
        fin  = cur;
        if (v && (m_active || u)) begin
            if (u) begin
                cx = '0; cy = '0;
            end else if (m_last) begin
                cx = '0; cy = m_y + 1'b1;
            end else begin
                cx = m_x + 1'b1; cy = m_y;
            end
            if (u) begin
                done = m_active;
                cur  = init_res();
            end
            cur      = add_pix(cur, cx, cy, d > thr);
            m_active = 1'b1;
            m_x      = cx;
            m_y      = cy;
            m_last   = l;
        end
        if (hs) exp_valid = 1'b0;
        if (done) begin
            if (exp_valid) begin
                exp_ovr = 1'b1;
                void'(sb.pop_front());
            end
            sb.push_back(fin);
            exp_out   = fin;
            exp_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        check("res_valid", 64'(res_valid), 64'(exp_valid));
        check("res_overrun", 64'(res_overrun), 64'(exp_ovr));
    endtask

    function automatic logic [DATA_W-1:0] pix(input int x, input int y);
        return (x == pat_sx && y == pat_sy) ? pat_sv : pat_v;
    endfunction

    task automatic sof_beat(input int w);
        applyStimulus(1'b1, pix(0, 0), 1'b1, w == 1);
    endtask

    // Remaining beats of a w x h frame after its start-of-frame beat.
    task automatic send_rest(input int w, input int h, input bit gaps);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (x == 0 && y == 0) continue;
                if (gaps) repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0);
                applyStimulus(1'b1, pix(x, y), 1'b0, x == w - 1);
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        cur = init_res(); exp_out = zero_res();
        exp_valid = 1'b0; exp_ovr = 1'b0; m_active = 1'b0; m_last = 1'b0;
        m_x = '0; m_y = '0;
    endtask

    function automatic res_t mk(input int c, input int sx, input int sy, input int x0, input int x1,
                                input int y0, input int y1, input int sxx, input int syy, input int sxy);
        res_t r;
        r.m00 = ACC_W'(c); r.m10 = ACC_W'(sx); r.m01 = ACC_W'(sy);
        r.xmin = COORD_W'(x0); r.xmax = COORD_W'(x1); r.ymin = COORD_W'(y0); r.ymax = COORD_W'(y1);
        r.m20 = ACC2_W'(sxx); r.m02 = ACC2_W'(syy); r.m11 = ACC2_W'(sxy);
        return r;
    endfunction

    initial begin
        arstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        thr = '0; res_ready = 1'b1;
        model_reset();
        pat_v = 8'd255; pat_sv = 8'd255; pat_sx = -1; pat_sy = -1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", zero_res());
        check("reset.res_valid", 64'(res_valid), 64'd0);
        check("reset.res_overrun", 64'(res_overrun), 64'd0);
        check("s_tready", 64'(s_tready), 64'd1);
        arstn = 1'b1;
        @(negedge clk);

        // Two all-255 4x3 frames; the first SOF after reset emits nothing.
        sof_beat(4);
        checkOutput("first_sof", zero_res());
        send_rest(4, 3, 1'b0);
        sof_beat(4);
        checkOutput("frame_full", mk(12, 18, 12, 0, 3, 0, 2, 42, 20, 18));
        send_rest(4, 3, 1'b0);

        // All-zero frame reports no active pixels.
        pat_v = 8'd0; pat_sv = 8'd0;
        sof_beat(4);
        send_rest(4, 3, 1'b0);
        thr = 8'd100; pat_v = 8'd100; pat_sv = 8'd101; pat_sx = 2; pat_sy = 1;
        sof_beat(4);
        checkOutput("frame_empty", mk(0, 0, 0, 'hFFF, 0, 'hFFF, 0, 0, 0, 0));

        // Single active pixel with random valid gaps; held result while res_ready is low.
        send_rest(4, 3, 1'b1);
        res_ready = 1'b0;
        pat_v = 8'd255; pat_sx = -1; pat_sy = -1;
        sof_beat(2);
        checkOutput("frame_single", mk(1, 2, 1, 2, 2, 1, 1, 4, 1, 2));
        send_rest(2, 2, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("hold", mk(1, 2, 1, 2, 2, 1, 1, 4, 1, 2));

        // Completion coincident with a handshake: new result loaded, no overrun.
        pat_v = 8'd200;
        res_ready = 1'b1;
        sof_beat(3);
        res_ready = 1'b0;
        checkOutput("coincident", mk(4, 2, 2, 0, 1, 0, 1, 2, 2, 1));
        check("coincident.overrun", 64'(res_overrun), 64'd0);
        send_rest(3, 2, 1'b0);

        // Completion while an unread result is pending: overwrite and flag overrun.
        sof_beat(2);
        checkOutput("overrun", mk(6, 6, 3, 0, 2, 0, 1, 10, 3, 3));
        check("overrun.flag", 64'(res_overrun), 64'd1);
        applyStimulus(1'b1, 8'd200, 1'b0, 1'b0);
        res_ready = 1'b1;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check("overrun.sticky", 64'(res_overrun), 64'd1);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(1'b1, 8'd200, 1'b0, 1'b1);
        #2 arstn = 1'b0;
        #1;
        checkOutput("async_reset", zero_res());
        check("async_reset.res_valid", 64'(res_valid), 64'd0);
        check("async_reset.res_overrun", 64'(res_overrun), 64'd0);
        model_reset();
        thr = 8'd0; pat_v = 8'd255;
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        sof_beat(4);
        checkOutput("post_reset_sof", zero_res());
        send_rest(4, 3, 1'b0);
        sof_beat(4);
        checkOutput("post_reset_frame", mk(12, 18, 12, 0, 3, 0, 2, 42, 20, 18));
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
